ps2_key_encoder: RTL

- Sits directly downstream of the key debounce stage in the PS2 TX path.
- Converts the debounced key level into PS2 Set-2 scancode bytes, with typematic auto-repeat:
  - make code on press;
  - make code repeated while the key is held;
  - break sequence F0+code on release.
- Presents the bytes one at a time to the PS2 TX serializer over a valid/ready handshake.

---
 rtl/ps2_key_pkg.sv | 20 ++
 rtl/key_edge_sync.sv | 43 ++++
 rtl/ps2_key_encoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ps2_key_pkg.sv
// rtl/ps2_key_pkg.sv - shared types and constants for the PS2 key encoder
package ps2_key_pkg;

  // Encoder FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_MAKE = 3'd1,
    HELD      = 3'd2,
    SEND_F0   = 3'd3,
    SEND_BRK  = 3'd4
  } state_e;

  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  // True for the states that offer a byte to the serializer
  function automatic logic state_sends(input state_e s);
    return (s == SEND_MAKE) || (s == SEND_F0) || (s == SEND_BRK);
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// rtl/key_edge_sync.sv - key level synchronizer, polarity normalizer and edge detector
module key_edge_sync #(
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_down,
  output logic press_evt,
  output logic rel_evt
);

  // Raw key_in level that means "released"
  localparam logic RELEASED_LVL = KEY_ACTIVE_LOW;

  logic sync1_q;
  logic sync2_q;
  logic key_down_q;
  logic pressed_lvl;

  // Synchronized level with polarity folded out: 1 always means pressed
  assign pressed_lvl = sync2_q ^ KEY_ACTIVE_LOW;

  // Two-flop synchronizer followed by the registered key state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= RELEASED_LVL;
      sync2_q    <= RELEASED_LVL;
      key_down_q <= 1'b0;
    end else begin
      sync1_q    <= key_in;
      sync2_q    <= sync1_q;
      key_down_q <= pressed_lvl;
    end
  end

  // Pulses are high in the cycle before key_down changes, so a consumer
  // registering on them acts on the same edge that updates key_down.
  assign press_evt = pressed_lvl & ~key_down_q;
  assign rel_evt   = ~pressed_lvl & key_down_q;
  assign key_down  = key_down_q;

endmodule

// File: rtl/ps2_key_encoder.sv
// rtl/ps2_key_encoder.sv - debounced key level to PS2 Set-2 make/break bytes with typematic repeat
module ps2_key_encoder
  import ps2_key_pkg::*;
#(
  parameter bit         KEY_ACTIVE_LOW = 1'b1,
  parameter logic [7:0] MAKE_CODE      = 8'h1C,
  parameter int         DELAY_CYC      = 25_000_000,
  parameter int         REPEAT_CYC     = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       key_down
);

  localparam int MAX_CYC = (DELAY_CYC > REPEAT_CYC) ? DELAY_CYC : REPEAT_CYC;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] DELAY_LOAD  = TW'(DELAY_CYC - 1);
  localparam logic [TW-1:0] REPEAT_LOAD = TW'(REPEAT_CYC - 1);

  logic press_evt;
  logic rel_evt;
  logic key_now;
  logic xfer;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          first_q, first_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;

  key_edge_sync #(
    .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .key_down (key_down),
    .press_evt(press_evt),
    .rel_evt  (rel_evt)
  );

  // Key state as it lands in key_down on this edge; the FSM decides on it
  // so press and release both reach the FSM with the same latency.
  assign key_now = press_evt | (key_down & ~rel_evt);
  assign xfer    = tx_valid_q & tx_ready;

  // Next-state logic: byte sequencing plus the repeat timer
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    timer_d = timer_q;
    if (state_q == HELD && timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (press_evt) begin
          state_d = SEND_MAKE;
          first_d = 1'b1;
        end
      end
      SEND_MAKE: begin
        if (xfer) begin
          // Repeat period counts from acceptance, so a stall never queues repeats
          timer_d = first_q ? DELAY_LOAD : REPEAT_LOAD;
          state_d = key_now ? HELD : SEND_F0;
        end
      end
      HELD: begin
        if (!key_now) begin
          state_d = SEND_F0;
        end else if (timer_q == '0) begin
          state_d = SEND_MAKE;
          first_d = 1'b0;
        end
      end
      SEND_F0: begin
        if (xfer) begin
          state_d = SEND_BRK;
        end
      end
      SEND_BRK: begin
        if (xfer) begin
          if (key_now) begin
            // Re-pressed during the break: start over with the long delay
            state_d = SEND_MAKE;
            first_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output byte follows the next state so valid/data are registered and stable
  always_comb begin
    tx_valid_d = state_sends(state_d);
    tx_data_d  = 8'h00;
    if (state_d == SEND_F0) begin
      tx_data_d = PS2_BREAK_PREFIX;
    end else if (state_d == SEND_MAKE || state_d == SEND_BRK) begin
      tx_data_d = MAKE_CODE;
    end
  end

  // State, timer and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      first_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      first_q    <= first_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;

endmodule
